// File: rtl/sample_capture_scheduler_if.sv
// Control/host bundle for the sample capture scheduler: prescaler config, buffer strobes,
// and the host dump handshake. master = scheduler side, slave = host/buffer side.
interface sample_capture_scheduler_if #(
  parameter int NUM_CHANNELS = 7,
  parameter int DIV_W        = 24,
  parameter int CH_W         = 3,
  parameter int IDX_W        = 4
);
  logic                    run;
  logic [DIV_W-1:0]        cfg_div;
  logic [NUM_CHANNELS-1:0] cfg_mask;
  logic                    buf_wr_en;
  logic [CH_W-1:0]         buf_wr_ch;
  logic                    buf_rd_en;
  logic [CH_W-1:0]         buf_rd_ch;
  logic [IDX_W-1:0]        buf_rd_idx;
  logic                    rd_req;
  logic [CH_W-1:0]         rd_ch;
  logic                    rd_ack;
  logic                    rd_err;
  logic                    rd_valid;
  logic                    rd_last;
  logic                    rd_ready;
  logic                    busy;
  logic                    overrun;

  modport master (
    input  run, cfg_div, cfg_mask, rd_req, rd_ch, rd_ready,
    output buf_wr_en, buf_wr_ch, buf_rd_en, buf_rd_ch, buf_rd_idx,
           rd_ack, rd_err, rd_valid, rd_last, busy, overrun
  );

  modport slave (
    output run, cfg_div, cfg_mask, rd_req, rd_ch, rd_ready,
    input  buf_wr_en, buf_wr_ch, buf_rd_en, buf_rd_ch, buf_rd_idx,
           rd_ack, rd_err, rd_valid, rd_last, busy, overrun
  );
endinterface

// File: rtl/sample_capture_scheduler.sv
// Prescaled capture sequencer for the per-channel sample shift buffers, with an
// interruptible host dump port; capture always preempts readout.
module sample_capture_scheduler #(
  parameter int NUM_CHANNELS = 7,
  parameter int DEPTH        = 10,
  parameter int DIV_W        = 24,
  parameter int CH_W         = 3,
  parameter int IDX_W        = 4
) (
  input logic                     clk,
  input logic                     reset,
  sample_capture_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, READ_ISSUE, READ_WAIT} state_t;

  localparam logic [CH_W:0]         NCH      = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [NUM_CHANNELS-1:0] ONE_CH = NUM_CHANNELS'(1);

  state_t                  state, state_n;
  logic [DIV_W-1:0]        cnt;
  logic                    pending, pend_clr, overrun;
  logic [NUM_CHANNELS-1:0] rem, rem_n, rem_next_bit;
  logic [CH_W-1:0]         ch_q, ch_n, wr_ch;
  logic [IDX_W-1:0]        idx, idx_n;
  logic                    resume, resume_n;
  logic                    tick, drop, rd_en, rd_ack, rd_err;

  // A tick that lands while one is still pending or a capture is running is lost.
  assign tick = bus.run && (cnt >= bus.cfg_div);
  assign drop = tick && (pending || (state == CAPTURE));
  assign rem_next_bit = rem & (rem - ONE_CH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      rem     <= '0;
      ch_q    <= '0;
      idx     <= '0;
      resume  <= 1'b0;
    end else begin
      if (bus.run) cnt <= tick ? '0 : cnt + DIV_W'(1);
      pending <= (pending && !pend_clr) || (tick && !drop);
      if (drop) overrun <= 1'b1;
      rem    <= rem_n;
      ch_q   <= ch_n;
      idx    <= idx_n;
      resume <= resume_n;
    end
  end

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    ch_n     = ch_q;
    idx_n    = idx;
    resume_n = resume;
    pend_clr = 1'b0;
    rd_en    = 1'b0;
    rd_ack   = 1'b0;
    rd_err   = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          state_n  = CAPTURE;
          rem_n    = bus.cfg_mask;
          pend_clr = 1'b1;
          resume_n = 1'b0;
        end else if (bus.rd_req) begin
          rd_ack = 1'b1;
          ch_n   = bus.rd_ch;
          if ({1'b0, bus.rd_ch} < NCH) begin
            idx_n   = '0;
            state_n = READ_ISSUE;
          end else begin
            rd_err = 1'b1;
          end
        end
      end
      CAPTURE: begin
        // An empty snapshot still spends one cycle here, then leaves.
        rem_n = rem_next_bit;
        if (rem_next_bit == '0) begin
          state_n  = resume ? READ_ISSUE : IDLE;
          resume_n = 1'b0;
        end
      end
      READ_ISSUE: begin
        if (pending) begin
          state_n  = CAPTURE;
          rem_n    = bus.cfg_mask;
          pend_clr = 1'b1;
          resume_n = 1'b1;
        end else begin
          rd_en   = 1'b1;
          state_n = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (bus.rd_ready) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = READ_ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wr_ch = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (rem[i]) wr_ch = CH_W'(i);
    end
  end

  assign bus.buf_wr_en  = (state == CAPTURE) && (rem != '0);
  assign bus.buf_wr_ch  = wr_ch;
  assign bus.buf_rd_en  = rd_en;
  assign bus.buf_rd_ch  = ch_q;
  assign bus.buf_rd_idx = idx;
  assign bus.rd_ack     = rd_ack;
  assign bus.rd_err     = rd_err;
  assign bus.rd_valid   = (state == READ_WAIT);
  assign bus.rd_last    = (state == READ_WAIT) && (idx == LAST_IDX);
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_sample_capture_scheduler.sv
// Directed bench for sample_capture_scheduler: capture sequencing, dumps, preemption,
// overrun, invalid channel and reset during readout.
module tb_sample_capture_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sample_capture_scheduler_if bus ();
  sample_capture_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0, passed = 0, failed = 0;
  int seen, n, beats, both, last_idx;
  int sel_ch[3] = '{0, 2, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input logic val, input int max, output int s, output int cyc);
    s = 0; cyc = 0;
    for (int i = 0; i < max; i++) begin
      if (bus.buf_wr_en === val) begin s = 1; break; end
      step(); cyc++;
    end
  endtask

  task automatic wait_busy(input logic val, input int max, output int s);
    s = 0;
    for (int i = 0; i < max; i++) begin
      if (bus.busy === val) begin s = 1; break; end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0; bus.cfg_div = '0; bus.cfg_mask = '0;
    bus.rd_req = 1'b0; bus.rd_ch = '0; bus.rd_ready = 1'b0;
    repeat (2) step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_wr_en", 32'(bus.buf_wr_en), 0);
    chk("rst_rd_en", 32'(bus.buf_rd_en), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_rd_idx", 32'(bus.buf_rd_idx), 0);
    reset = 1'b0;

    // all channels, period 10
    bus.cfg_div = 24'd9; bus.cfg_mask = 7'h7F; bus.run = 1'b1;
    wait_wr(1'b1, 30, seen, n);
    chk("t1_first_tick", seen, 1);
    for (int i = 0; i < 7; i++) begin
      chk("t1_wr_en", 32'(bus.buf_wr_en), 1);
      chk("t1_wr_ch", 32'(bus.buf_wr_ch), i);
      chk("t1_overrun", 32'(bus.overrun), 0);
      step();
    end
    chk("t1_wr_en_done", 32'(bus.buf_wr_en), 0);
    chk("t1_busy_done", 32'(bus.busy), 0);
    wait_wr(1'b1, 20, seen, n);
    chk("t1_second_tick", seen, 1);
    chk("t1_period", 7 + n, 10);

    // sparse mask then empty mask
    bus.cfg_mask = 7'b0100101;
    wait_wr(1'b0, 20, seen, n);
    wait_wr(1'b1, 20, seen, n);
    chk("t2_sparse_tick", seen, 1);
    for (int j = 0; j < 3; j++) begin
      chk("t2_wr_en", 32'(bus.buf_wr_en), 1);
      chk("t2_wr_ch", 32'(bus.buf_wr_ch), sel_ch[j]);
      step();
    end
    chk("t2_wr_en_done", 32'(bus.buf_wr_en), 0);
    bus.cfg_mask = 7'h00;
    wait_busy(1'b1, 20, seen);
    chk("t2_empty_busy", seen, 1);
    chk("t2_empty_no_wr", 32'(bus.buf_wr_en), 0);
    step();
    chk("t2_empty_busy_1cyc", 32'(bus.busy), 0);
    chk("t2_empty_no_wr2", 32'(bus.buf_wr_en), 0);
    bus.run = 1'b0;

    // full dump of channel 3, stall on beat 4
    bus.rd_ch = 3'd3; bus.rd_req = 1'b1; bus.rd_ready = 1'b1;
    #1;
    chk("t3_ack", 32'(bus.rd_ack), 1);
    chk("t3_no_err", 32'(bus.rd_err), 0);
    step();
    bus.rd_req = 1'b0;
    for (int b = 0; b < 10; b++) begin
      chk("t3_rd_en", 32'(bus.buf_rd_en), 1);
      chk("t3_rd_ch", 32'(bus.buf_rd_ch), 3);
      chk("t3_issue_idx", 32'(bus.buf_rd_idx), b);
      chk("t3_issue_valid", 32'(bus.rd_valid), 0);
      if (b == 4) bus.rd_ready = 1'b0;
      step();
      chk("t3_valid", 32'(bus.rd_valid), 1);
      chk("t3_idx", 32'(bus.buf_rd_idx), b);
      chk("t3_last", 32'(bus.rd_last), (b == 9) ? 1 : 0);
      chk("t3_wait_rd_en", 32'(bus.buf_rd_en), 0);
      if (b == 4) begin
        repeat (4) begin
          step();
          chk("t3_stall_valid", 32'(bus.rd_valid), 1);
          chk("t3_stall_idx", 32'(bus.buf_rd_idx), 4);
          chk("t3_stall_rd_en", 32'(bus.buf_rd_en), 0);
        end
        bus.rd_ready = 1'b1;
      end
      step();
    end
    chk("t3_done_busy", 32'(bus.busy), 0);
    chk("t3_done_valid", 32'(bus.rd_valid), 0);

    // single tick injected mid-dump of channel 2
    bus.cfg_mask = 7'h7F;
    bus.rd_ch = 3'd2; bus.rd_req = 1'b1;
    #1;
    chk("t4_ack", 32'(bus.rd_ack), 1);
    step();
    bus.rd_req = 1'b0;
    repeat (3) step();
    chk("t4_wait_b1_valid", 32'(bus.rd_valid), 1);
    chk("t4_wait_b1_idx", 32'(bus.buf_rd_idx), 1);
    bus.rd_ready = 1'b0; bus.cfg_div = 24'd0; bus.run = 1'b1;
    step();
    bus.run = 1'b0; bus.cfg_div = 24'd9;
    chk("t4_hold_valid", 32'(bus.rd_valid), 1);
    chk("t4_hold_idx", 32'(bus.buf_rd_idx), 1);
    chk("t4_tick_waits", 32'(bus.buf_wr_en), 0);
    bus.rd_ready = 1'b1;
    step();
    chk("t4_preempt_no_rd", 32'(bus.buf_rd_en), 0);
    chk("t4_preempt_no_wr", 32'(bus.buf_wr_en), 0);
    step();
    for (int i = 0; i < 7; i++) begin
      chk("t4_cap_wr_en", 32'(bus.buf_wr_en), 1);
      chk("t4_cap_wr_ch", 32'(bus.buf_wr_ch), i);
      chk("t4_cap_rd_en", 32'(bus.buf_rd_en), 0);
      chk("t4_cap_valid", 32'(bus.rd_valid), 0);
      step();
    end
    chk("t4_resume_rd_en", 32'(bus.buf_rd_en), 1);
    chk("t4_resume_idx", 32'(bus.buf_rd_idx), 2);
    chk("t4_resume_ch", 32'(bus.buf_rd_ch), 2);
    beats = 0; both = 0; last_idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      if (bus.buf_wr_en && bus.buf_rd_en) both++;
      if (bus.rd_valid && bus.rd_ready) begin
        beats++;
        if (bus.rd_last) last_idx = int'(bus.buf_rd_idx);
      end
      step();
    end
    chk("t4_done", 32'(bus.busy), 0);
    chk("t4_beats", beats, 8);
    chk("t4_last_idx", last_idx, 9);
    chk("t4_no_overlap", both, 0);
    chk("t4_overrun", 32'(bus.overrun), 0);

    // overrun from a too-short period, then invalid channel
    bus.cfg_div = 24'd3; bus.run = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.overrun) begin seen = 1; break; end
      step();
    end
    chk("t5_overrun_set", seen, 1);
    bus.run = 1'b0;
    repeat (20) step();
    chk("t5_overrun_sticky", 32'(bus.overrun), 1);
    chk("t5_idle", 32'(bus.busy), 0);
    bus.rd_ch = 3'd7; bus.rd_req = 1'b1;
    #1;
    chk("t5_bad_ack", 32'(bus.rd_ack), 1);
    chk("t5_bad_err", 32'(bus.rd_err), 1);
    step();
    bus.rd_req = 1'b0;
    #1;
    chk("t5_bad_busy", 32'(bus.busy), 0);
    chk("t5_bad_ack_pulse", 32'(bus.rd_ack), 0);
    repeat (3) step();
    chk("t5_bad_no_valid", 32'(bus.rd_valid), 0);
    chk("t5_bad_no_rd_en", 32'(bus.buf_rd_en), 0);
    chk("t5_overrun_still", 32'(bus.overrun), 1);

    // reset during READ_WAIT
    bus.rd_ready = 1'b0; bus.rd_ch = 3'd1; bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    step();
    chk("t6_in_wait", 32'(bus.rd_valid), 1);
    reset = 1'b1;
    step();
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_valid", 32'(bus.rd_valid), 0);
    chk("t6_last", 32'(bus.rd_last), 0);
    chk("t6_rd_en", 32'(bus.buf_rd_en), 0);
    chk("t6_wr_en", 32'(bus.buf_wr_en), 0);
    chk("t6_overrun", 32'(bus.overrun), 0);
    chk("t6_rd_idx", 32'(bus.buf_rd_idx), 0);
    chk("t6_rd_ch", 32'(bus.buf_rd_ch), 0);
    chk("t6_ack", 32'(bus.rd_ack), 0);
    reset = 1'b0;
    repeat (3) step();
    chk("t6_after_busy", 32'(bus.busy), 0);
    chk("t6_after_rd_en", 32'(bus.buf_rd_en), 0);
    chk("t6_after_valid", 32'(bus.rd_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
